// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// single-entry output holding register behind a valid/ack handshake.
module uart_rx_core #(
    parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       ferr,
    output logic       overrun
);

    localparam logic [31:0] HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
    localparam logic [31:0] FULL_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state, state_next;
    logic        sync1, rxd_s;
    logic [31:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shreg, shreg_next;
    logic        good_stop, bad_stop;

    // Idle-high synchroniser so that reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 32'd1;
        idx_next   = idx;
        shreg_next = shreg;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxd_s) state_next = START;
            end
            START: begin
                // Re-check at mid start bit; a high line here was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next        = '0;
                    shreg_next[idx] = rxd_s;
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        good_stop  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rxd_s) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // A delivery coinciding with an ack replaces the held byte instead of clearing valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata    <= '0;
            rx_valid <= 1'b0;
            rx_busy  <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rx_busy <= (state_next != IDLE);
            ferr    <= bad_stop;
            overrun <= 1'b0;
            if (good_stop) begin
                if (!rx_valid || rx_ack) begin
                    rdata    <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core (H=4): a reference model turns issued frames into
// expected deliver/overrun/ferr events which an independent monitor checks on the outputs.
module tb_uart_rx_core;

    localparam int H   = 4;
    localparam int BIT = 2 * H;
    localparam int LAT = 19 * H + 3;

    localparam int EV_DELIVER = 0;
    localparam int EV_OVERRUN = 1;
    localparam int EV_FERR    = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rdata;
    logic       rx_valid, rx_busy, ferr, overrun;

    uart_rx_core #(.CLK_PER_HALF_BIT(H)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .rx_busy  (rx_busy),
        .ferr     (ferr),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cycle;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         cycle;
    } pend_t;

    ev_t   exp_q[$];
    pend_t pend_q[$];
    pend_t model_p;
    ev_t   mon_e;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    logic  m_valid = 1'b0;
    logic  prev_valid = 1'b0;
    logic  prev_ack = 1'b0;
    bit    cons_done = 1'b0;

    function automatic ev_t mk_ev(input int k, input logic [7:0] d, input int c);
        ev_t e;
        e.kind  = k;
        e.data  = d;
        e.cycle = c;
        return e;
    endfunction

    // Reference model: resolves each issued frame at its stop-sample edge.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_valid = 1'b0;
            pend_q.delete();
        end else begin
            if (pend_q.size() > 0 && pend_q[0].cycle == cyc) begin
                model_p = pend_q.pop_front();
                if (!model_p.stop_ok) begin
                    exp_q.push_back(mk_ev(EV_FERR, 8'h00, cyc));
                    if (rx_ack && m_valid) m_valid = 1'b0;
                end else if (!m_valid || rx_ack) begin
                    exp_q.push_back(mk_ev(EV_DELIVER, model_p.data, cyc));
                    m_valid = 1'b1;
                end else begin
                    exp_q.push_back(mk_ev(EV_OVERRUN, 8'h00, cyc));
                end
            end else if (rx_ack && m_valid) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check_output(input int kind, input logic [7:0] data);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_event: got kind=%0d data=%02h cycle=%0d, expected no event",
                     kind, data, cyc);
        end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.kind != kind || mon_e.cycle != cyc ||
                (kind == EV_DELIVER && mon_e.data !== data)) begin
                bad++;
                $display("[TB] FAIL event: got kind=%0d data=%02h cycle=%0d, expected kind=%0d data=%02h cycle=%0d",
                         kind, data, cyc, mon_e.kind, mon_e.data, mon_e.cycle);
            end
        end
    endtask

    // Monitor: a delivery is valid rising, or valid held across an accepting cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid && (!prev_valid || prev_ack)) check_output(EV_DELIVER, rdata);
            if (overrun) check_output(EV_OVERRUN, 8'h00);
            if (ferr)    check_output(EV_FERR, 8'h00);
        end
        prev_valid = rx_valid;
        prev_ack   = rx_ack;
    end

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic ack_once();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int k = 0;
        while (!rx_valid && k < bound) begin
            wait_cycles(1);
            k++;
        end
        if (!rx_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_valid: got timeout after %0d cycles expected rx_valid=1", bound);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_it);
        pend_t p;
        p.data    = b;
        p.stop_ok = stop_bit;
        p.cycle   = cyc + LAT;
        if (expect_it) pend_q.push_back(p);
        rxd = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(BIT);
        end
        rxd = stop_bit;
        wait_cycles(BIT);
        rxd = 1'b1;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0;
        int busy_seen;
        logic [7:0] b;

        wait_cycles(3);
        check_val("reset_outputs", int'({rdata, rx_valid, rx_busy, ferr, overrun}), 0);
        reset = 1'b0;
        wait_cycles(2 * BIT);

        // Test 1: 0xA5, latency measured from the edge that registers rxd low.
        n0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                wait_valid(200);
                check_val("t1_latency", cyc - n0 - 1, 19 * H + 2);
                check_val("t1_rdata", int'(rdata), 'hA5);
                wait_cycles(3);
                ack_once();
                check_val("t1_valid_cleared", int'(rx_valid), 0);
            end
        join
        wait_cycles(BIT);

        // Test 2: short low glitch on an idle line.
        rxd = 1'b0;
        wait_cycles(2);
        rxd = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_busy) busy_seen = 1;
            wait_cycles(1);
        end
        check_val("t2_busy_pulsed", busy_seen, 1);
        check_val("t2_busy_idle", int'(rx_busy), 0);
        check_val("t2_no_valid", int'(rx_valid), 0);

        // Test 3: framing error, long break, then recovery.
        send_frame(8'h3C, 1'b0, 1'b1);
        rxd = 1'b0;
        wait_cycles(40);
        check_val("t3_break_busy", int'(rx_busy), 1);
        check_val("t3_no_valid", int'(rx_valid), 0);
        rxd = 1'b1;
        wait_cycles(BIT);
        check_val("t3_break_released", int'(rx_busy), 0);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_valid(50);
        check_val("t3_rdata", int'(rdata), 'h81);
        ack_once();
        wait_cycles(BIT);

        // Test 4a: back-to-back without ack, second byte dropped.
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        wait_cycles(2);
        check_val("t4a_rdata_held", int'(rdata), 'h11);
        check_val("t4a_valid_held", int'(rx_valid), 1);
        ack_once();
        wait_cycles(BIT);

        // Test 4b: ack lands on the stop-sample edge of the second frame.
        send_frame(8'h11, 1'b1, 1'b1);
        n0 = cyc;
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                wait_cycles(LAT - 1);
                ack_once();
                check_val("t4b_rdata", int'(rdata), 'h22);
                check_val("t4b_valid_kept", int'(rx_valid), 1);
            end
        join
        check_val("t4b_ack_edge", cyc - n0 >= LAT ? 1 : 0, 1);
        ack_once();
        wait_cycles(BIT);

        // Test 5: reset in the middle of 0xFF data bits.
        rxd = 1'b0;
        wait_cycles(BIT);
        rxd = 1'b1;
        wait_cycles(4 * BIT + H);
        reset = 1'b1;
        wait_cycles(1);
        for (int i = 0; i < 3; i++) begin
            check_val("t5_reset_outputs", int'({rdata, rx_valid, rx_busy, ferr, overrun}), 0);
            wait_cycles(1);
        end
        reset = 1'b0;
        wait_cycles(4 * BIT);
        check_val("t5_idle_after_reset", int'(rx_busy), 0);
        send_frame(8'h00, 1'b1, 1'b1);
        wait_valid(50);
        check_val("t5_rdata", int'(rdata), 0);
        ack_once();
        wait_cycles(BIT);

        // Test 6: random bytes against a consumer with random ack delay.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    b = 8'($urandom);
                    wait_cycles(BIT * $urandom_range(0, 2));
                    send_frame(b, 1'b1, 1'b1);
                end
                cons_done = 1'b1;
            end
            begin
                while (!cons_done) begin
                    if (rx_valid) begin
                        wait_cycles(BIT * $urandom_range(0, 10));
                        ack_once();
                    end else begin
                        wait_cycles(1);
                    end
                end
            end
        join
        wait_cycles(2 * BIT);
        if (rx_valid) ack_once();
        wait_cycles(20);

        check_val("exp_queue_drained", exp_q.size(), 0);
        check_val("pend_queue_drained", pend_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
